phy_lane_arbiter: RTL

Two-lane round-robin arbiter that merges two byte-wide input streams onto one shared byte lane in the PHY datapath. It sits upstream of the PHY serializer and shares that lane between two requesters. Each lane has a small FIFO with valid/ready flow control. Output is registered, with valid/ready backpressure.

---
 rtl/phy_arb_pkg.sv | 15 +
 rtl/phy_byte_fifo.sv | 80 ++++++++
 rtl/phy_lane_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/phy_arb_pkg.sv
// Shared definitions for the two-lane PHY byte arbiter: default byte width,
// lane index constants and the FIFO level-counter width helper.
package phy_arb_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    // A level counter must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/phy_byte_fifo.sv
// Synchronous byte FIFO with registered read data that always shows the
// current head entry; full/empty come from the level counter, not the pointers.
module phy_byte_fifo
    import phy_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              push_ok, pop_ok;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign rd_data = rd_data_reg;

    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop_ok);

    always_comb begin
        level_next = level_reg;
        if (push_ok && !pop_ok) begin
            level_next = level_reg + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_next = level_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // The read register is loaded from the next head address; a byte written
    // into that very slot this cycle is forwarded so a lone entry is visible
    // one cycle after it is pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            rd_data_reg <= push_data;
        end else begin
            rd_data_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

endmodule

// File: rtl/phy_lane_arbiter.sv
// Two-lane round-robin byte arbiter feeding the PHY serializer lane.
// Define ARB_STRICT_ALT_EN for fixed alternating (TDM) slots instead of work-conserving grants.
module phy_lane_arbiter
    import phy_arb_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  in0_data,
    input  logic                               in0_valid,
    output logic                               in0_ready,
    input  logic [DATA_W-1:0]                  in1_data,
    input  logic                               in1_valid,
    output logic                               in1_ready,
    output logic [DATA_W-1:0]                  out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_lane,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo0_level,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo1_level
);

    localparam int LVL_W = level_width(FIFO_DEPTH);

    logic              ready_en_reg;
    logic              ptr_reg, ptr_next;
    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              out_lane_reg, out_lane_next;
    logic              load;

    logic [1:0]        lane_valid, lane_ready, lane_push, lane_pop;
    logic [1:0]        lane_full, lane_empty;
    logic [DATA_W-1:0] lane_wr_data [2];
    logic [DATA_W-1:0] lane_rd_data [2];
    logic [LVL_W-1:0]  lane_level   [2];

    assign lane_valid      = {in1_valid, in0_valid};
    assign lane_wr_data[0] = in0_data;
    assign lane_wr_data[1] = in1_data;

    assign in0_ready   = lane_ready[0];
    assign in1_ready   = lane_ready[1];
    assign fifo0_level = lane_level[0];
    assign fifo1_level = lane_level[1];
    assign out_data    = out_data_reg;
    assign out_valid   = out_valid_reg;
    assign out_lane    = out_lane_reg;

    // Ready is built from registered state only, so no input reaches it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_ready[gi] = ready_en_reg && !lane_full[gi];
            assign lane_push[gi]  = lane_valid[gi] && lane_ready[gi];

            phy_byte_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (lane_push[gi]),
                .push_data (lane_wr_data[gi]),
                .pop       (lane_pop[gi]),
                .rd_data   (lane_rd_data[gi]),
                .full      (lane_full[gi]),
                .empty     (lane_empty[gi]),
                .level     (lane_level[gi])
            );
        end
    endgenerate

    assign load = !out_valid_reg || out_ready;

`ifdef ARB_STRICT_ALT_EN
    // Fixed slot schedule: the pointer lane owns every load slot.
    always_comb begin
        ptr_next       = ptr_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_lane_next  = out_lane_reg;
        lane_pop       = 2'b00;
        if (load) begin
            ptr_next      = ~ptr_reg;
            out_lane_next = ptr_reg;
            if (!lane_empty[ptr_reg]) begin
                lane_pop[ptr_reg] = 1'b1;
                out_valid_next    = 1'b1;
                out_data_next     = lane_rd_data[ptr_reg];
            end else begin
                out_valid_next = 1'b0;
                out_data_next  = '0;
            end
        end
    end
`else
    logic grant;
    logic grant_valid;

    always_comb begin
        ptr_next       = ptr_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_lane_next  = out_lane_reg;
        lane_pop       = 2'b00;
        grant          = ptr_reg;
        grant_valid    = 1'b0;
        if (load) begin
            if (!lane_empty[0] && !lane_empty[1]) begin
                grant       = ptr_reg;
                ptr_next    = ~ptr_reg;
                grant_valid = 1'b1;
            end else if (!lane_empty[0]) begin
                grant       = LANE0;
                ptr_next    = LANE1;
                grant_valid = 1'b1;
            end else if (!lane_empty[1]) begin
                grant       = LANE1;
                ptr_next    = LANE0;
                grant_valid = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
            if (grant_valid) begin
                lane_pop[grant] = 1'b1;
                out_valid_next  = 1'b1;
                out_data_next   = lane_rd_data[grant];
                out_lane_next   = grant;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_en_reg  <= 1'b0;
            ptr_reg       <= LANE0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_lane_reg  <= LANE0;
        end else begin
            ready_en_reg  <= 1'b1;
            ptr_reg       <= ptr_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_lane_reg  <= out_lane_next;
        end
    end

endmodule
